// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch PC with trap/EPC handling and optional return-address stack
// Define PC_UNIT_RAS_EN to build in the return-address stack.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EN,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call_valid,
  input  logic            ret_valid,
  input  logic            trap_valid,
  input  logic            trap_ret,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic [XLEN-1:0] EPC,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] epc_d;
  logic [XLEN-1:0] ras_top;
  logic            mis_d;
  logic            push;
  logic            pop;
  logic            ras_avail;

  assign PC_PLUS4 = PC + XLEN'(4);

  always_comb begin
    pc_d  = PC;
    epc_d = EPC;
    mis_d = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    if (trap_valid) begin
      pc_d  = TRAP_VECTOR;
      epc_d = PC;
    end else if (EN) begin
      if (trap_ret) begin
        pc_d = EPC;
      end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
        pc_d  = TRAP_VECTOR;
        epc_d = PC;
        mis_d = 1'b1;
      end else if (redirect_valid) begin
        pc_d = redirect_target;
        push = call_valid;
      end else if (ret_valid && !call_valid && ras_avail) begin
        // a simultaneous call_valid suppresses the return
        pc_d = ras_top;
        pop  = 1'b1;
      end else begin
        pc_d = PC_PLUS4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC         <= RESET_VECTOR;
      EPC        <= '0;
      misaligned <= 1'b0;
    end else begin
      PC         <= pc_d;
      EPC        <= epc_d;
      misaligned <= mis_d;
    end
  end

`ifdef PC_UNIT_RAS_EN
  localparam int             PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0]    CNT_FULL = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   sp_q;
  logic [PW:0]     cnt_q;

  assign ras_top   = ras_mem[sp_q - PW'(1)];
  assign ras_avail = (cnt_q != '0);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);

  // sp_q wraps, so a push into a full stack overwrites the oldest entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (push) begin
      sp_q <= sp_q + PW'(1);
      if (cnt_q != CNT_FULL) cnt_q <= cnt_q + (PW+1)'(1);
    end else if (pop) begin
      sp_q  <= sp_q - PW'(1);
      cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem[sp_q] <= PC_PLUS4;
  end
`else
  logic unused_ras;
  assign ras_top    = '0;
  assign ras_avail  = 1'b0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign unused_ras = ^{push, pop};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a queue-based reference model
module tb_pc_unit;
  localparam logic [31:0] TRAP  = 32'h0000_0100;
  localparam int          DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EN = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        call_valid = 1'b0;
  logic        ret_valid = 1'b0;
  logic        trap_valid = 1'b0;
  logic        trap_ret = 1'b0;
  logic [31:0] PC, PC_PLUS4, EPC;
  logic        misaligned, ras_empty, ras_full;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_epc;
  bit          m_mis;
  logic [31:0] m_ras[$];

  pc_unit dut (
    .clk(clk), .rst(rst), .EN(EN),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .call_valid(call_valid), .ret_valid(ret_valid),
    .trap_valid(trap_valid), .trap_ret(trap_ret),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .EPC(EPC), .misaligned(misaligned),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic model_reset;
    m_pc = 32'h0; m_epc = 32'h0; m_mis = 1'b0; m_ras.delete();
  endtask

  // Reference behaviour for one rising edge, from the priority rules
  task automatic model_edge;
    logic [31:0] seq;
    seq   = m_pc + 32'd4;
    m_mis = 1'b0;
    if (trap_valid) begin
      m_epc = m_pc; m_pc = TRAP;
    end else if (EN) begin
      if (trap_ret) m_pc = m_epc;
      else if (redirect_valid && redirect_target[1:0] != 2'b00) begin
        m_epc = m_pc; m_pc = TRAP; m_mis = 1'b1;
      end else if (redirect_valid) begin
        if (RAS_ON && call_valid) begin
          m_ras.push_back(seq);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        m_pc = redirect_target;
      end else if (RAS_ON && ret_valid && !call_valid && m_ras.size() > 0)
        m_pc = m_ras.pop_back();
      else m_pc = seq;
    end
  endtask

  task automatic idle;
    EN = 0; redirect_valid = 0; redirect_target = '0; call_valid = 0;
    ret_valid = 0; trap_valid = 0; trap_ret = 0;
  endtask

  task automatic step;
    @(posedge clk); model_edge(); @(negedge clk);
  endtask

  task automatic do_reset;
    idle(); rst = 0; @(negedge clk); model_reset(); rst = 1;
  endtask

  task automatic test_reset;
    idle(); rst = 0;
    @(negedge clk); @(negedge clk);
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
    checks++; if (EPC !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want %h", EPC, 32'h0); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", misaligned); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_ras_empty: got %b want 1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras_full: got %b want 0", ras_full); end
    model_reset(); rst = 1;
  endtask

  task automatic test_sequential;
    do_reset();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL seq_start: got %h want %h", PC, 32'h0); end
    EN = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (PC !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, PC, 32'(i * 4)); end
    end
  endtask

  task automatic test_stall;
    do_reset(); EN = 1; step(); step();
    EN = 0; redirect_valid = 1; redirect_target = 32'h80;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (PC !== 32'h8) begin errors++; $display("FAIL stall_pc%0d: got %h want %h", i, PC, 32'h8); end
    end
  endtask

  task automatic test_misaligned;
    do_reset(); EN = 1; redirect_valid = 1; redirect_target = 32'h20; step();
    checks++; if (PC !== 32'h20) begin errors++; $display("FAIL mis_setup: got %h want %h", PC, 32'h20); end
    redirect_target = 32'h42; step();
    checks++; if (PC !== TRAP) begin errors++; $display("FAIL mis_pc: got %h want %h", PC, TRAP); end
    checks++; if (EPC !== 32'h20) begin errors++; $display("FAIL mis_epc: got %h want %h", EPC, 32'h20); end
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", misaligned); end
    redirect_valid = 0; trap_ret = 1; step();
    checks++; if (PC !== 32'h20) begin errors++; $display("FAIL mis_tret_pc: got %h want %h", PC, 32'h20); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b want 0", misaligned); end
    checks++; if (EPC !== 32'h20) begin errors++; $display("FAIL mis_tret_epc: got %h want %h", EPC, 32'h20); end
  endtask

  task automatic test_trap_stall;
    do_reset(); EN = 1; redirect_valid = 1; redirect_target = 32'h30; step();
    idle(); trap_valid = 1; step();
    checks++; if (PC !== TRAP) begin errors++; $display("FAIL trap_pc: got %h want %h", PC, TRAP); end
    checks++; if (EPC !== 32'h30) begin errors++; $display("FAIL trap_epc: got %h want %h", EPC, 32'h30); end
  endtask

  task automatic test_wrap;
    do_reset(); EN = 1; redirect_valid = 1; redirect_target = 32'hFFFF_FFFC; step();
    checks++; if (PC_PLUS4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want %h", PC_PLUS4, 32'h0); end
    redirect_valid = 0; step();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want %h", PC, 32'h0); end
    redirect_valid = 1; redirect_target = 32'h40; step();
    idle();
    #2 rst = 0;
    #1;
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h want %h", PC, 32'h0); end
    #1 rst = 1; model_reset();
    step();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL post_reset_hold: got %h want %h", PC, 32'h0); end
  endtask

`ifdef PC_UNIT_RAS_EN
  task automatic test_ras;
    logic [31:0] exp_ret [5];
    exp_ret = '{32'h44, 32'h34, 32'h24, 32'h14, 32'h18};
    do_reset(); EN = 1;
    for (int i = 0; i < 5; i++) begin
      redirect_valid = 1; call_valid = 1; redirect_target = 32'((i + 1) * 16);
      step();
      checks++; if (PC !== 32'((i + 1) * 16)) begin errors++; $display("FAIL call_pc%0d: got %h want %h", i, PC, 32'((i + 1) * 16)); end
      checks++; if (ras_full !== (i >= 3)) begin errors++; $display("FAIL call_full%0d: got %b want %b", i, ras_full, (i >= 3)); end
    end
    redirect_valid = 0; call_valid = 0; ret_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (PC !== exp_ret[i]) begin errors++; $display("FAIL ret_pc%0d: got %h want %h", i, PC, exp_ret[i]); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
  endtask
`else
  task automatic test_no_ras;
    do_reset(); EN = 1; redirect_valid = 1; call_valid = 1; redirect_target = 32'h10; step();
    redirect_valid = 0; call_valid = 0; ret_valid = 1; step();
    checks++; if (PC !== 32'h14) begin errors++; $display("FAIL noras_ret_pc: got %h want %h", PC, 32'h14); end
    checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      errors++; $display("FAIL noras_flags: got empty=%b full=%b want 1/0", ras_empty, ras_full);
    end
  endtask
`endif

  task automatic test_random;
    bit exp_empty, exp_full;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(63) == 0) begin
        #2 rst = 0;
        #1;
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rnd_async_reset@%0d: got %h want %h", n, PC, 32'h0); end
        #1 rst = 1; model_reset();
      end
      EN             = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(2) == 0);
      redirect_target = $urandom_range(255) << 2;
      if ($urandom_range(7) == 0) redirect_target[1:0] = 2'($urandom_range(1, 3));
      call_valid = ($urandom_range(2) == 0);
      ret_valid  = ($urandom_range(2) == 0);
      trap_valid = ($urandom_range(15) == 0);
      trap_ret   = ($urandom_range(15) == 0);
      step();
      exp_empty = RAS_ON ? (m_ras.size() == 0) : 1'b1;
      exp_full  = RAS_ON ? (m_ras.size() == DEPTH) : 1'b0;
      checks++; if (PC !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", n, PC, m_pc); end
      checks++; if (EPC !== m_epc) begin errors++; $display("FAIL rnd_epc@%0d: got %h want %h", n, EPC, m_epc); end
      checks++; if (PC_PLUS4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4@%0d: got %h want %h", n, PC_PLUS4, m_pc + 32'd4); end
      checks++; if (misaligned !== m_mis) begin errors++; $display("FAIL rnd_mis@%0d: got %b want %b", n, misaligned, m_mis); end
      checks++; if (ras_empty !== exp_empty || ras_full !== exp_full) begin
        errors++; $display("FAIL rnd_ras@%0d: got empty=%b full=%b want %b/%b", n, ras_empty, ras_full, exp_empty, exp_full);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_misaligned();
    test_trap_stall();
    test_wrap();
`ifdef PC_UNIT_RAS_EN
    test_ras();
`else
    test_no_ras();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
